// File: rtl/pm_arbiter.sv
// pm_arbiter
// Round-robin arbiter sharing one packet FIFO write port among NUM_FLOWS
// packet-manager flows. Grants are one-cycle pulses issued only when the
// FIFO was ready in the decision cycle. The granted flow's write strobe and
// command bundle are collected two cycles after the decision and forwarded
// to the FIFO through registers. Grant and miss statistics are kept for
// debug readout.
//
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   req, ack       per-flow request / acknowledge (eligible = req & ack)
//   grant          registered one-hot (or zero) grant
//   fifo_wr_ready  FIFO can accept a write (sampled in the decision cycle)
//   flow_wr_en     per-flow write strobes
//   flow_cmd       flattened command bundles, flow k at [k*CMD_W +: CMD_W]
//   fifo_wr_en     registered write strobe to the FIFO
//   fifo_cmd       registered command to the FIFO
//   grant_count    total grants issued (wraps)
//   miss_count     grants not followed by the expected write (wraps)
//   err_spurious   sticky flag: write strobe from an unexpected flow
module pm_arbiter #(
  parameter int NUM_FLOWS = 4,
  parameter int CMD_W     = 131,
  parameter int CNT_W     = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_FLOWS-1:0]       req,
  input  logic [NUM_FLOWS-1:0]       ack,
  output logic [NUM_FLOWS-1:0]       grant,
  input  logic                       fifo_wr_ready,
  input  logic [NUM_FLOWS-1:0]       flow_wr_en,
  input  logic [NUM_FLOWS*CMD_W-1:0] flow_cmd,
  output logic                       fifo_wr_en,
  output logic [CMD_W-1:0]           fifo_cmd,
  output logic [CNT_W-1:0]           grant_count,
  output logic [CNT_W-1:0]           miss_count,
  output logic                       err_spurious
);

  localparam int IDX_W = (NUM_FLOWS > 1) ? $clog2(NUM_FLOWS) : 1;
  localparam logic [IDX_W:0]   NF_L   = (IDX_W+1)'(NUM_FLOWS);
  localparam logic [IDX_W-1:0] LAST_L = IDX_W'(NUM_FLOWS - 1);

  logic [NUM_FLOWS-1:0] grant_r;
  logic [IDX_W-1:0]     ptr_r;
  logic                 g_valid_r;
  logic [IDX_W-1:0]     g_idx_r;
  logic                 w_valid_r;
  logic [IDX_W-1:0]     w_idx_r;
  logic                 fifo_wr_en_r;
  logic [CMD_W-1:0]     fifo_cmd_r;
  logic [CNT_W-1:0]     grant_count_r;
  logic [CNT_W-1:0]     miss_count_r;
  logic                 err_spurious_r;

  logic [NUM_FLOWS-1:0] eligible_s;
  logic                 win_found_s;
  logic [IDX_W-1:0]     win_idx_s;
  logic                 grant_take_s;
  logic [IDX_W-1:0]     ptr_next_s;
  logic [NUM_FLOWS-1:0] grant_next_s;
  logic [NUM_FLOWS-1:0] expect_mask_s;
  logic                 w_hit_s;
  logic                 spurious_s;
  logic [CMD_W-1:0]     cmd_sel_s;

  // The flow currently holding a grant cannot win again in the same cycle.
  assign eligible_s = req & ack & ~grant_r;

  // Round-robin search: first eligible flow at ptr, ptr+1, ... modulo NUM_FLOWS.
  always_comb begin
    logic [IDX_W:0] sum_v;
    logic [IDX_W:0] cand_v;
    logic           take_v;
    win_found_s = 1'b0;
    win_idx_s   = '0;
    sum_v       = '0;
    cand_v      = '0;
    take_v      = 1'b0;
    for (int i = 0; i < NUM_FLOWS; i++) begin
      sum_v = {1'b0, ptr_r} + (IDX_W+1)'(i);
      if (sum_v >= NF_L) begin
        cand_v = sum_v - NF_L;
      end else begin
        cand_v = sum_v;
      end
      take_v      = eligible_s[cand_v[IDX_W-1:0]] & ~win_found_s;
      win_idx_s   = take_v ? cand_v[IDX_W-1:0] : win_idx_s;
      win_found_s = win_found_s | take_v;
    end
  end

  // Grant decision, next pointer and the one-hot grant vector.
  always_comb begin
    grant_take_s = fifo_wr_ready & win_found_s;
    grant_next_s = '0;
    if (win_idx_s == LAST_L) begin
      ptr_next_s = '0;
    end else begin
      ptr_next_s = win_idx_s + IDX_W'(1);
    end
    if (grant_take_s) begin
      grant_next_s[win_idx_s] = 1'b1;
    end else begin
      grant_next_s = '0;
    end
  end

  // Write collection: only the flow tracked in stage W may strobe this cycle.
  always_comb begin
    expect_mask_s = '0;
    if (w_valid_r) begin
      expect_mask_s[w_idx_r] = 1'b1;
    end else begin
      expect_mask_s = '0;
    end
    w_hit_s    = w_valid_r & (flow_wr_en[w_idx_r] == 1'b1);
    spurious_s = |(flow_wr_en & ~expect_mask_s);
    cmd_sel_s  = flow_cmd[w_idx_r*CMD_W +: CMD_W];
  end

  // Arbitration state: grant register, pointer and the G/W tracking pipeline.
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_r   <= '0;
      ptr_r     <= '0;
      g_valid_r <= 1'b0;
      g_idx_r   <= '0;
      w_valid_r <= 1'b0;
      w_idx_r   <= '0;
    end else begin
      grant_r   <= grant_next_s;
      g_valid_r <= grant_take_s;
      g_idx_r   <= win_idx_s;
      w_valid_r <= g_valid_r;
      w_idx_r   <= g_idx_r;
      if (grant_take_s) begin
        ptr_r <= ptr_next_s;
      end else begin
        ptr_r <= ptr_r;
      end
    end
  end

  // FIFO write port: forward the collected strobe, hold the command on a miss.
  always_ff @(posedge clk) begin
    if (rst) begin
      fifo_wr_en_r <= 1'b0;
      fifo_cmd_r   <= '0;
    end else if (w_hit_s) begin
      fifo_wr_en_r <= 1'b1;
      fifo_cmd_r   <= cmd_sel_s;
    end else begin
      fifo_wr_en_r <= 1'b0;
      fifo_cmd_r   <= fifo_cmd_r;
    end
  end

  // Statistics counters and the sticky spurious-write flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_count_r  <= '0;
      miss_count_r   <= '0;
      err_spurious_r <= 1'b0;
    end else begin
      if (grant_take_s) begin
        grant_count_r <= grant_count_r + CNT_W'(1);
      end else begin
        grant_count_r <= grant_count_r;
      end
      if (w_valid_r && !w_hit_s) begin
        miss_count_r <= miss_count_r + CNT_W'(1);
      end else begin
        miss_count_r <= miss_count_r;
      end
      err_spurious_r <= err_spurious_r | spurious_s;
    end
  end

  assign grant        = grant_r;
  assign fifo_wr_en   = fifo_wr_en_r;
  assign fifo_cmd     = fifo_cmd_r;
  assign grant_count  = grant_count_r;
  assign miss_count   = miss_count_r;
  assign err_spurious = err_spurious_r;

endmodule

// File: doc/pm_arbiter.md
# pm_arbiter

Round-robin arbiter that shares one packet FIFO write port among NUM_FLOWS packet-manager flows. It accepts per-flow request/ack lines, issues one-cycle grants only while the FIFO can accept data, and forwards the granted flow's write strobe and command fields to the FIFO through a registered multiplexer. It also keeps grant and miss statistics for debug readout.

## Interface

- NUM_FLOWS, 4, number of requesting flows (2..16)
- CMD_W, 131, width of one flow's command bundle {size[10:0], d_mac[47:0], s_mac[47:0], ethertype[15:0], payload[7:0]}
- CNT_W, 32, width of statistics counters

- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- req  in  NUM_FLOWS  per-flow arb_request
- ack  in  NUM_FLOWS  per-flow arb_ack; a flow with ack=0 is ineligible
- grant  out  NUM_FLOWS  one-hot (or zero) arb_grant, registered
- fifo_wr_ready  in  1  FIFO can accept a write
- flow_wr_en  in  NUM_FLOWS  per-flow fifo_wr_enable
- flow_cmd  in  NUM_FLOWS*CMD_W  flattened command bundles, flow k at [k*CMD_W +: CMD_W]
- fifo_wr_en  out  1  registered write strobe to FIFO
- fifo_cmd  out  CMD_W  registered command to FIFO
- grant_count  out  CNT_W  total grants issued
- miss_count  out  CNT_W  grants not followed by the expected write
- err_spurious  out  1  sticky: write strobe from a flow not expected this cycle

## Operation

- Eligible set E = req & ack. Arbitration runs every cycle with fifo_wr_ready=1 and E≠0; otherwise grant next cycle is 0.
- Round-robin pointer ptr (log2 NUM_FLOWS bits): winner = first k in ptr, ptr+1, …, wrapping modulo NUM_FLOWS, with E[k]=1. After a grant, ptr ← winner+1 mod NUM_FLOWS (wrap from NUM_FLOWS-1 to 0). No grant leaves ptr unchanged.
- A flow whose grant bit is high in the current cycle is masked out of E for that cycle (no double grant across consecutive cycles to the same flow unless it re-requests after the grant cycle).
- Two-stage tracking pipeline: stage G holds {valid, idx} of the grant currently driven; stage W holds {valid, idx} of the grant from the previous cycle, whose write is expected this cycle.
- Collection: when W.valid, if flow_wr_en[W.idx]=1 then next cycle fifo_wr_en=1 and fifo_cmd=flow_cmd[W.idx]; else fifo_wr_en=0, fifo_cmd holds its previous value, miss_count += 1.
- Any flow_wr_en[k]=1 with k≠W.idx or W.valid=0 sets err_spurious; the strobe is not forwarded. Only logic-1 counts; X/Z treated as 0.
- grant_count += 1 per issued grant. Both counters wrap modulo 2^CNT_W.
- At most one grant, one forwarded write per cycle; back-to-back grants to different flows on consecutive cycles are allowed.

## Timing

- Reset values: grant=0, fifo_wr_en=0, fifo_cmd=0, grant_count=0, miss_count=0, err_spurious=0, ptr=0, G.valid=W.valid=0. err_spurious clears only on rst.
- Latency: E sampled at cycle t (with fifo_wr_ready=1) → grant at t+1 → flow_wr_en expected at t+2 → fifo_wr_en/fifo_cmd at t+3.
- fifo_wr_ready is sampled in the decision cycle only; a drop during the grant cycle is not retracted (the flow will omit its write and miss_count increments).
- rst mid-operation: all in-flight G/W entries discarded, no write forwarded in the cycle after rst, no counters touched.
- Simultaneous: a collected write and a new grant in the same cycle are independent; grant_count and miss_count may both increment in one cycle.

## Test plan

- Single flow: req[0]=1 steady, ready=1, flow 0 echoes grant as wr_en one cycle later → grant[0] every other cycle, fifo_wr_en at t+3 with fifo_cmd = flow 0 bundle, miss_count=0.
- All four flows request continuously, ptr=0 → grant order 0,1,2,3,0… one per cycle; grant_count=8 after 8 grant cycles; ptr wraps 3→0.
- fifo_wr_ready=0 for 5 cycles with req=4'b1010 → grant stays 0, ptr unchanged; on ready=1 grant=4'b0010 next cycle.
- ack[2]=0 with req=4'b0100 → no grant ever; req[2]&ack[2] → grant[2].
- Granted flow 1 withholds wr_en → fifo_wr_en stays 0, miss_count=1; flow 3 asserts wr_en unprompted → err_spurious=1 until rst.
- rst asserted the cycle after grant[2] → next cycle grant=0, fifo_wr_en=0, all counters 0, ptr=0.
